// File: rtl/ms_span_addr10.sv
// Span address sequencer: accepts a start address and word count, then issues one
// address per non-stalled cycle to the downstream transparent address latch.
module ms_span_addr10 #(
    parameter int AW   = 10,
    parameter int STEP = 1      // legal values: 1, 2, 4
) (
    input  logic          clk,
    input  logic          reset_l,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] length,
    input  logic          stall,
    output logic          busy,
    output logic [AW-1:0] addr,
    output logic          addr_g,
    output logic          done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [AW-1:0] STEP_W = AW'(STEP);
    localparam logic [AW-1:0] ONE_W  = AW'(1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [AW-1:0] rem_q,   rem_d;

    always_comb begin
        // NOTE: every next-state signal defaults to its held value first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = start_addr;
                    rem_d   = length;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // An unknown stall fails this test and falls through to "hold".
                if (stall == 1'b0) begin
                    if (rem_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d = addr_q + STEP_W;   // carry-out dropped: wraps mod 2^AW
                        rem_d  = rem_q - ONE_W;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and abandons any span without a done pulse;
        // all three registers are cleared so the latch sees address 0 afterwards.
        if (!reset_l) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign addr   = addr_q;
    assign addr_g = (state_q == S_RUN) & ~stall;
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_ms_span_addr10.sv
// Scoreboard bench for ms_span_addr10: expected addresses are queued when a span is
// started and popped each cycle the DUT raises addr_g.
module tb_ms_span_addr10;

    logic       clk = 1'b0;
    logic       reset_l;
    logic       start, start4;
    logic [9:0] start_addr, start_addr4;
    logic [9:0] length, length4;
    logic       stall;
    logic       stall4;
    logic       busy, busy4;
    logic [9:0] addr, addr4;
    logic       addr_g, addr_g4;
    logic       done, done4;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    ms_span_addr10 #(.AW(10), .STEP(1)) u_dut (
        .clk(clk), .reset_l(reset_l), .start(start), .start_addr(start_addr),
        .length(length), .stall(stall), .busy(busy), .addr(addr),
        .addr_g(addr_g), .done(done)
    );

    ms_span_addr10 #(.AW(10), .STEP(4)) u_dut4 (
        .clk(clk), .reset_l(reset_l), .start(start4), .start_addr(start_addr4),
        .length(length4), .stall(stall4), .busy(busy4), .addr(addr4),
        .addr_g(addr_g4), .done(done4)
    );

    // Starts a span on the selected DUT, scores every issued address, optionally stalls
    // a window of cycles and pokes start during RUN and DONE. Enters/leaves at posedge+1.
    task automatic run_span(input bit use4, input logic [9:0] sa, input logic [9:0] len,
                            input int stall_from, input int stall_cnt, input bit poke,
                            output int done_k, output int issued);
        int         step;
        logic [9:0] nxt, e, a;
        logic       g, b, d;
        step   = use4 ? 4 : 1;
        nxt    = sa;
        done_k = -1;
        issued = 0;
        for (int i = 0; i <= int'(len); i++) begin
            exp_q.push_back(nxt);
            nxt = nxt + 10'(step);
        end
        if (use4) begin start4 = 1'b1; start_addr4 = sa; length4 = len; end
        else      begin start  = 1'b1; start_addr  = sa; length  = len; end
        @(posedge clk); #1;
        start  = 1'b0;
        start4 = 1'b0;
        for (int k = 0; k < int'(len) + stall_cnt + 8; k++) begin
            stall = !use4 && (k >= stall_from) && (k < stall_from + stall_cnt);
            start = poke && (k == 1 || k == int'(len) + 1 + stall_cnt);
            if (poke) begin start_addr = 10'h200; length = 10'h005; end
            @(negedge clk);
            g = use4 ? addr_g4 : addr_g;
            b = use4 ? busy4   : busy;
            d = use4 ? done4   : done;
            a = use4 ? addr4   : addr;
            checks++;
            if (b !== 1'b1) begin
                errors++;
                $display("FAIL busy_in_span k=%0d got %b want 1", k, b);
            end
            if (g === 1'b1) begin
                checks++;
                issued++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_issue k=%0d got addr %h want no issue", k, a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL issue_addr k=%0d got %h want %h", k, a, e);
                    end
                end
            end else if (stall) begin
                checks++;
                if (exp_q.size() == 0 || a !== exp_q[0]) begin
                    errors++;
                    $display("FAIL stall_hold k=%0d got addr %h g=%b want held pending addr", k, a, g);
                end
            end
            if (d === 1'b1) begin
                done_k = k;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        stall = 1'b0;
        checks++;
        if (done_k < 0) begin
            errors++;
            $display("FAIL done_timeout got no done want done pulse");
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_issues got %0d unissued want 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        b = use4 ? busy4 : busy;
        d = use4 ? done4 : done;
        checks++;
        if (b !== 1'b0 || d !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_done got busy=%b done=%b want 0 0", b, d);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({busy, addr_g, done, addr} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b g=%b done=%b addr=%h want 0 0 0 000",
                     busy, addr_g, done, addr);
        end
        checks++;
        if ({busy4, addr_g4, done4, addr4} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state4 got busy=%b g=%b done=%b addr=%h want 0 0 0 000",
                     busy4, addr_g4, done4, addr4);
        end
        reset_l = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic expect_span(input string name, input int dk, input int iss,
                               input int want_dk, input int want_iss);
        checks++;
        if (dk != want_dk || iss != want_iss) begin
            errors++;
            $display("FAIL %s got done_k=%0d issued=%0d want done_k=%0d issued=%0d",
                     name, dk, iss, want_dk, want_iss);
        end
    endtask

    task automatic test_no_stall();
        int dk, iss;
        run_span(1'b0, 10'h010, 10'd3, 0, 0, 1'b0, dk, iss);
        expect_span("no_stall_timing", dk, iss, 4, 4);
    endtask

    task automatic test_wrap();
        int dk, iss;
        run_span(1'b0, 10'h3FE, 10'd2, 0, 0, 1'b0, dk, iss);
        expect_span("wrap_step1", dk, iss, 3, 3);
        run_span(1'b1, 10'h3FC, 10'd1, 0, 0, 1'b0, dk, iss);
        expect_span("wrap_step4", dk, iss, 2, 2);
        run_span(1'b1, 10'h3FE, 10'd1, 0, 0, 1'b0, dk, iss);
        expect_span("wrap_step4_odd", dk, iss, 2, 2);
    endtask

    task automatic test_stall();
        int dk, iss;
        run_span(1'b0, 10'h100, 10'd3, 1, 3, 1'b0, dk, iss);
        expect_span("stall_timing", dk, iss, 7, 4);
    endtask

    task automatic test_single_max();
        int dk, iss;
        run_span(1'b0, 10'h155, 10'd0, 0, 0, 1'b0, dk, iss);
        expect_span("single_word", dk, iss, 1, 1);
        run_span(1'b0, 10'h000, 10'h3FF, 0, 0, 1'b0, dk, iss);
        expect_span("max_length", dk, iss, 1024, 1024);
    endtask

    task automatic test_handshake();
        int dk, iss;
        run_span(1'b0, 10'h050, 10'd3, 0, 0, 1'b1, dk, iss);
        expect_span("start_while_busy", dk, iss, 4, 4);
    endtask

    task automatic test_reset_mid();
        int dk, iss;
        start = 1'b1; start_addr = 10'h010; length = 10'd5;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (addr_g !== 1'b1 || addr !== 10'h010 + 10'(k)) begin
                errors++;
                $display("FAIL pre_reset_issue k=%0d got g=%b addr=%h want 1 %h",
                         k, addr_g, addr, 10'h010 + 10'(k));
            end
            if (k < 3) begin @(posedge clk); #1; end
        end
        reset_l = 1'b0;
        @(posedge clk); #1;
        reset_l = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, addr_g, done, addr} !== 13'd0) begin
                errors++;
                $display("FAIL reset_mid k=%0d got busy=%b g=%b done=%b addr=%h want 0 0 0 000",
                         k, busy, addr_g, done, addr);
            end
            @(posedge clk); #1;
        end
        run_span(1'b0, 10'h020, 10'd0, 0, 0, 1'b0, dk, iss);
        expect_span("post_reset_span", dk, iss, 1, 1);
    endtask

    initial begin
        reset_l = 1'b0;
        start = 1'b0; start4 = 1'b0;
        start_addr = '0; start_addr4 = '0;
        length = '0; length4 = '0;
        stall = 1'b0; stall4 = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_no_stall();
        test_wrap();
        test_stall();
        test_single_max();
        test_handshake();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ms_span_addr10.md
Name: ms_span_addr10

Overview:
- Span address sequencer for the memory-span (ms) datapath.
- Sits directly upstream of the 10-bit transparent address latch stage and drives that latch's data input (d_in) and gate (g).
- Accepts a start address and word count through a start/busy handshake, then issues one 10-bit address per non-stalled cycle.
- Wraps modulo 1024 and pulses done when the span completes.

Parameters:
- AW, 10, address/count width; the latch stage fixes this at 10.
- STEP, 1, address increment per issued word; legal values 1, 2, 4.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- reset_l  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- start  input  1  request a new span; honoured only in IDLE.
- start_addr  input  AW  first address of the span; sampled with start.
- length  input  AW  word count minus one (0 means 1 word, 1023 means 1024 words); sampled with start.
- stall  input  1  downstream hold; while high, no address is issued and state is frozen.
- busy  output  1  high whenever the state is not IDLE.
- addr  output  AW  current address; connects to the latch d_in.
- addr_g  output  1  address-valid gate; connects to the latch g.
- done  output  1  one-cycle pulse after the last word is issued.

Behaviour:
- Reset (reset_l=0 at a clock edge), taking effect at the next edge regardless of state:
  - state=IDLE; addr=0; remaining=0.
  - busy=0, addr_g=0, done=0.
  - Any in-flight span is abandoned and done is NOT pulsed.
- States: IDLE, RUN, DONE (2-bit encoded register).
- IDLE:
  - If start=1 at an edge: addr<=start_addr, remaining<=length, state<=RUN.
  - Otherwise addr holds its value.
- RUN:
  - addr_g = ~stall, combinational from a registered state and the stall input; it is the only combinational output path.
  - At an edge with stall=0:
    - If remaining==0: state<=DONE; addr holds the last issued value.
    - Else: addr<=(addr+STEP) mod 2^AW; remaining<=remaining-1.
  - At an edge with stall=1: addr, remaining and state all hold. No address is skipped or duplicated.
- DONE:
  - done=1 for exactly this one cycle; addr_g=0.
  - state<=IDLE at the next edge unconditionally.
- Latency: start sampled at edge N gives the first addr valid (addr_g=1 if not stalled) in cycle N+1. The last word of an unstalled span of length L is issued in cycle N+1+L. done is high in cycle N+2+L.
- busy = (state!=IDLE). It is high in RUN and DONE.
- start while busy (RUN or DONE) is ignored; it is neither queued nor latched.
  - start coincident with the DONE→IDLE edge is therefore dropped; upstream must wait for busy=0.
- Arithmetic:
  - The address adder is AW bits with carry-out discarded, so 0x3FF+1 = 0x000.
  - With STEP>1, wrap is likewise mod 1024 (e.g. 0x3FE+4 = 0x002).
- start_addr and length are don't-care outside the start cycle.
- stall is don't-care outside RUN.
- X on stall during RUN must not corrupt state; the bench drives it clean.
- A span may hold for an unbounded time under stall; there is no timeout.

Test Plan:
1. Span with no stall: start_addr=0x010, length=3, stall=0 → addr_g high for 4 cycles with addr 0x010, 0x011, 0x012, 0x013; done high in the 5th cycle after start; busy high for those 5 cycles, then 0.
2. Wrap-around: start_addr=0x3FE, length=2 → issued addresses 0x3FE, 0x3FF, 0x000, then done. Repeat with STEP=4, start_addr=0x3FC, length=1 → issued 0x3FC, then 0x000.
3. Stall mid-span: start_addr=0x100, length=3, stall=1 for 3 cycles beginning on the 2nd issue cycle → addr holds 0x101 with addr_g=0 for those 3 cycles; the issued sequence is exactly 0x100, 0x101, 0x102, 0x103; done is delayed by 3 cycles.
4. Single word and max length: length=0 → one addr_g cycle, then done. length=0x3FF from 0x000 → 1024 issues ending at 0x3FF, then done.
5. Handshake violations: pulse start with start_addr=0x200 during RUN and again during DONE of an active span → neither start is taken, the active sequence is unaffected, and state is IDLE afterwards.
6. Reset mid-operation: reset_l=0 for one edge during RUN at addr=0x013 → next cycle shows busy=0, addr=0, addr_g=0, done=0 with no done pulse. Then start_addr=0x020, length=0 → normal single-word span.
